// File: rtl/phv_mcast_dispatcher.sv
// PHV multicast dispatcher: latches one PHV and fans it out to up to four
// destination queues selected by a 4-bit mask carried inside the PHV. Each
// queue accepts on its own handshake; the next PHV is taken once every
// masked queue has accepted (or in the same cycle as the final accepts).
module phv_mcast_dispatcher #(
  parameter int PHV_LEN   = 1024,
  parameter int MASK_OFF  = 141,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic [PHV_LEN-1:0]   phv_in,
  input  logic                 phv_in_valid,
  output logic                 phv_in_ready,
  output logic [PHV_LEN-1:0]   phv_out_0,
  output logic [PHV_LEN-1:0]   phv_out_1,
  output logic [PHV_LEN-1:0]   phv_out_2,
  output logic [PHV_LEN-1:0]   phv_out_3,
  output logic                 phv_out_valid_0,
  output logic                 phv_out_valid_1,
  output logic                 phv_out_valid_2,
  output logic                 phv_out_valid_3,
  input  logic                 phv_fifo_ready_0,
  input  logic                 phv_fifo_ready_1,
  input  logic                 phv_fifo_ready_2,
  input  logic                 phv_fifo_ready_3,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic                 busy
);

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t               state_q, state_d;
  logic [PHV_LEN-1:0]   hold_q, hold_d;
  logic [3:0]           pend_q, pend_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;

  logic [3:0] rdy_vec;
  logic [3:0] in_mask;
  logic       dispatching;
  logic       done;
  logic       handshake;

  assign rdy_vec     = {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0};
  assign in_mask     = phv_in[MASK_OFF +: 4];
  assign dispatching = (state_q == DISPATCH);
  // Every still-pending queue is accepting this cycle.
  assign done        = dispatching && ((pend_q & ~rdy_vec) == 4'b0000);
  assign phv_in_ready = (state_q == IDLE) || done;
  assign handshake   = phv_in_valid && phv_in_ready;

  // Next-state: per-port accept clearing, completion, and new PHV load.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    drop_d  = drop_q;
    pkt_d   = pkt_q;

    if (dispatching) begin
      pend_d = pend_q & ~rdy_vec;
    end

    if (done) begin
      state_d = IDLE;
      if (pkt_q != '1) begin
        pkt_d = pkt_q + CNT_WIDTH'(1);
      end
    end

    // A load in the completion cycle overrides the return to IDLE.
    if (handshake) begin
      hold_d = phv_in;
      pend_d = in_mask;
      if (in_mask == 4'b0000) begin
        state_d = IDLE;
        if (drop_q != '1) begin
          drop_d = drop_q + CNT_WIDTH'(1);
        end
      end else begin
        state_d = DISPATCH;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      hold_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
      pkt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      pkt_q   <= pkt_d;
    end
  end

  assign phv_out_0 = hold_q;
  assign phv_out_1 = hold_q;
  assign phv_out_2 = hold_q;
  assign phv_out_3 = hold_q;

  assign phv_out_valid_0 = dispatching && pend_q[0];
  assign phv_out_valid_1 = dispatching && pend_q[1];
  assign phv_out_valid_2 = dispatching && pend_q[2];
  assign phv_out_valid_3 = dispatching && pend_q[3];

  assign drop_cnt = drop_q;
  assign pkt_cnt  = pkt_q;
  assign busy     = dispatching;

endmodule
